stage3_execute: RTL and testbench
=================================

// Module: stage3_execute
// PURPOSE
//  Execute stage of the 5-stage SCU pipeline; the consumer of the ID/EX outputs driven by the decode stage.
//  Runs the ALU on rd1/rd2/imm and keeps the zero/neg flags that decode reads.
//  Resolves brz/brn/j and captures its results into an internal EX/MEM pipeline register.
//  Exports a registered redirect and flush to fetch and decode.
// PARAMETERS
//  DW      32  datapath width (rd1, rd2, imm, PC, ALU result)
//  RW      6   register-index width (rd, rs, rt)
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  stall       in   1   hold request from the memory stage
//  in_imm      in   DW  sign-extended immediate (ID/EX)
//  in_rd       in   RW  destination register index (ID/EX)
//  in_rd1      in   DW  register operand A (ID/EX)
//  in_rd2      in   DW  register operand B (ID/EX)
//  in_PC       in   DW  PC of this instruction (ID/EX)
//  in_brz, in_brn, in_j, in_regw, in_wai, in_memw, in_memr, in_alusrc  in 1  control bits (ID/EX)
//  in_aluop    in   3   ALU operation (ID/EX)
//  in_rs, in_rt in  RW  source indices for forwarding; ignored unless EX_FWD_EN is defined
//  zero, neg   out  1   registered flag outputs, wired back to decode
//  br_taken    out  1   registered redirect request, also used as the squash/flush for fetch/decode
//  br_target   out  DW  registered redirect PC
//  out_alu     out  DW  EX/MEM ALU result / memory address
//  out_wdata   out  DW  EX/MEM store data (forwarded rd2)
//  out_rd      out  RW  EX/MEM destination index
//  out_PC      out  DW  EX/MEM PC
//  out_regw, out_wai, out_memw, out_memr  out 1  EX/MEM control bits
// BEHAVIOUR
//  Reset
//  - rst=1 at posedge: every output register and both flags go to 0.
//  - Reset wins over stall and over a pending branch; an instruction in flight is discarded.
//  Operand selection
//  - A = rd1.
//  - B = in_alusrc ? in_imm : rd2.
//  ALU ops (aluop)
//  - 000 ADD: A+B
//  - 001 INC: A+imm
//  - 010 NEG: 0-A
//  - 011 SUB: A-B
//  - 100 PASS_B: B
//  - 101..111: result 0
//  - All arithmetic is modulo 2^DW; carry and overflow are dropped.
//  Memory instructions
//  - If in_memr or in_memw: out_alu = A (address) and out_wdata = rd2; the ALU result is not used.
//  Flags
//  - Flags update only when an unsquashed, unstalled instruction with regw=1, memr=0, memw=0 is captured.
//  - zero = (result==0); neg = result[DW-1].
//  - All other instructions hold both flags.
//  Branch
//  - taken = in_j | (in_brz & zero) | (in_brn & neg), using the current flag registers (the previous ALU op).
//  - Captured as br_taken with br_target = rd1.
//  - br_taken is a one-cycle pulse.
//  Squash
//  - In the cycle br_taken=1, the instruction presented on the inputs is a wrong-path instruction.
//  - It is captured as a bubble: regw, wai, memw, memr forced to 0; no flag update; no branch.
//  - A taken branch whose own wrong-path successor is a branch: the successor is squashed, so only one redirect occurs.
//  Stall
//  - stall=1: all EX/MEM registers, flags, br_taken and br_target hold their values; inputs are ignored.
//  - A br_taken pulse coinciding with stall is extended until the first non-stalled edge.
//  Latency
//  - 1 cycle from ID/EX inputs to EX/MEM outputs and to br_taken.
//  - Throughput: one instruction per unstalled cycle.
// CONFIGURATION
//  EX_FWD_EN defined
//  - Operand substitution: rd1 is replaced by the previous captured ALU result when in_rs==out_rd && out_regw && !out_memr.
//  - rd2 (and out_wdata) follow the same rule using in_rt.
//  - Index 0 is never forwarded.
//  EX_FWD_EN undefined
//  - in_rs and in_rt are unused; operands come straight from rd1/rd2.
//  - Software inserts NOPs between dependent instructions.
// TESTING
//  1. rst=1 for 2 cycles, then 0 -> all outputs 0, zero=0, neg=0, br_taken=0.
//  2. ADD rd1=5, rd2=7, alusrc=0, regw=1, rd=3 -> next cycle: out_alu=12, out_rd=3, out_regw=1, zero=0, neg=0.
//  3. SUB 9-9 -> zero=1; next BRZ rd1=0x40 -> br_taken=1 for 1 cycle, br_target=0x40;
//     following ADD (regw=1) is captured with out_regw=0, flags unchanged.
//  4. NEG rd1=1 -> out_alu=0xFFFFFFFF, neg=1; LD rd1=0x20, regw=1, memr=1 -> out_alu=0x20, flags unchanged.
//  5. stall=1 for 3 cycles while inputs change -> outputs and flags unchanged;
//     release -> the current input is captured on the next edge.
//  6. EX_FWD_EN: ADD r2=3+4, then ADD with rs=2, stale rd1=0, rd2=1 -> out_alu=8;
//     undefined -> out_alu=1; rst asserted mid-stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/stage3_execute.sv
// rtl/stage3_execute.sv - SCU execute stage: ALU, flags, branch resolve, EX/MEM register (optional EX_FWD_EN forwarding)
module stage3_execute #(
    parameter int DW = 32,
    parameter int RW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic [DW-1:0] in_imm,
    input  logic [RW-1:0] in_rd,
    input  logic [DW-1:0] in_rd1,
    input  logic [DW-1:0] in_rd2,
    input  logic [DW-1:0] in_PC,
    input  logic          in_brz,
    input  logic          in_brn,
    input  logic          in_j,
    input  logic          in_regw,
    input  logic          in_wai,
    input  logic          in_memw,
    input  logic          in_memr,
    input  logic          in_alusrc,
    input  logic [2:0]    in_aluop,
    input  logic [RW-1:0] in_rs,
    input  logic [RW-1:0] in_rt,
    output logic          zero,
    output logic          neg,
    output logic          br_taken,
    output logic [DW-1:0] br_target,
    output logic [DW-1:0] out_alu,
    output logic [DW-1:0] out_wdata,
    output logic [RW-1:0] out_rd,
    output logic [DW-1:0] out_PC,
    output logic          out_regw,
    output logic          out_wai,
    output logic          out_memw,
    output logic          out_memr
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_NEG  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_rd2;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] ex_result;
    logic          mem_op;
    logic          squash;
    logic          take;
    logic          upd_flags;

`ifdef EX_FWD_EN
    logic fwd_ok;
    logic fwd_a;
    logic fwd_b;

    // Loads produce their value in MEM, so only non-load ALU results are forwardable.
    assign fwd_ok = out_regw && !out_memr;
    assign fwd_a  = fwd_ok && (in_rs != '0) && (in_rs == out_rd);
    assign fwd_b  = fwd_ok && (in_rt != '0) && (in_rt == out_rd);
    assign op_a   = fwd_a ? out_alu : in_rd1;
    assign op_rd2 = fwd_b ? out_alu : in_rd2;
`else
    logic unused_fwd_idx;

    assign unused_fwd_idx = &{1'b0, in_rs, in_rt};
    assign op_a           = in_rd1;
    assign op_rd2         = in_rd2;
`endif

    assign op_b = in_alusrc ? in_imm : op_rd2;

    always_comb begin
        alu_res = '0;
        case (in_aluop)
            OP_ADD:  alu_res = op_a + op_b;
            OP_INC:  alu_res = op_a + in_imm;
            OP_NEG:  alu_res = '0 - op_a;
            OP_SUB:  alu_res = op_a - op_b;
            OP_PASS: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    assign mem_op    = in_memr | in_memw;
    assign ex_result = mem_op ? op_a : alu_res;

    // The instruction arriving while a redirect is visible is already on the wrong path.
    assign squash    = br_taken;
    assign take      = !squash && (in_j || (in_brz && zero) || (in_brn && neg));
    assign upd_flags = !squash && in_regw && !mem_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero      <= 1'b0;
            neg       <= 1'b0;
            br_taken  <= 1'b0;
            br_target <= '0;
            out_alu   <= '0;
            out_wdata <= '0;
            out_rd    <= '0;
            out_PC    <= '0;
            out_regw  <= 1'b0;
            out_wai   <= 1'b0;
            out_memw  <= 1'b0;
            out_memr  <= 1'b0;
        end else if (!stall) begin
            br_taken  <= take;
            br_target <= op_a;
            out_alu   <= ex_result;
            out_wdata <= op_rd2;
            out_rd    <= in_rd;
            out_PC    <= in_PC;
            out_regw  <= in_regw && !squash;
            out_wai   <= in_wai && !squash;
            out_memw  <= in_memw && !squash;
            out_memr  <= in_memr && !squash;
            if (upd_flags) begin
                zero <= (alu_res == '0);
                neg  <= alu_res[DW-1];
            end
        end
    end

endmodule

// File: tb/tb_stage3_execute.sv
// tb/tb_stage3_execute.sv - directed-vector bench for stage3_execute
module tb_stage3_execute;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [31:0] in_imm, in_rd1, in_rd2, in_PC;
    logic [5:0]  in_rd, in_rs, in_rt;
    logic        in_brz, in_brn, in_j, in_regw, in_wai, in_memw, in_memr, in_alusrc;
    logic [2:0]  in_aluop;
    logic        zero, neg, br_taken;
    logic [31:0] br_target, out_alu, out_wdata, out_PC;
    logic [5:0]  out_rd;
    logic        out_regw, out_wai, out_memw, out_memr;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    stage3_execute #(.DW(32), .RW(6)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .in_imm(in_imm), .in_rd(in_rd), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_PC(in_PC),
        .in_brz(in_brz), .in_brn(in_brn), .in_j(in_j), .in_regw(in_regw), .in_wai(in_wai),
        .in_memw(in_memw), .in_memr(in_memr), .in_alusrc(in_alusrc), .in_aluop(in_aluop),
        .in_rs(in_rs), .in_rt(in_rt),
        .zero(zero), .neg(neg), .br_taken(br_taken), .br_target(br_target),
        .out_alu(out_alu), .out_wdata(out_wdata), .out_rd(out_rd), .out_PC(out_PC),
        .out_regw(out_regw), .out_wai(out_wai), .out_memw(out_memw), .out_memr(out_memr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        in_imm = 0; in_rd = 0; in_rd1 = 0; in_rd2 = 0; in_PC = 0; in_rs = 0; in_rt = 0;
        in_brz = 0; in_brn = 0; in_j = 0; in_regw = 0; in_wai = 0;
        in_memw = 0; in_memr = 0; in_alusrc = 0; in_aluop = 3'b000;
    endtask

    task automatic alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] rd);
        nop();
        in_aluop = op; in_rd1 = a; in_rd2 = b; in_rd = rd; in_regw = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] fwd_exp;
        // Reset with busy-looking inputs
        nop();
        stall = 0; rst = 1;
        in_j = 1; in_regw = 1; in_rd1 = 32'h1234; in_rd = 6'd7; in_memr = 1;
        step(); step();
        check("rst out_alu", out_alu, 0);
        check("rst out_regw", {31'b0, out_regw}, 0);
        check("rst out_memr", {31'b0, out_memr}, 0);
        check("rst out_rd", {26'b0, out_rd}, 0);
        check("rst br_taken", {31'b0, br_taken}, 0);
        check("rst br_target", br_target, 0);
        check("rst flags", {30'b0, zero, neg}, 0);
        rst = 0;

        // ADD 5+7
        alu(3'b000, 5, 7, 6'd3); in_PC = 32'h100;
        step();
        check("add out_alu", out_alu, 12);
        check("add out_rd", {26'b0, out_rd}, 3);
        check("add out_regw", {31'b0, out_regw}, 1);
        check("add out_PC", out_PC, 32'h100);
        check("add flags", {30'b0, zero, neg}, 0);

        // SUB 9-9 -> zero, then BRZ, then wrong-path ADD carrying its own BRZ
        alu(3'b011, 9, 9, 6'd4);
        step();
        check("sub out_alu", out_alu, 0);
        check("sub zero", {31'b0, zero}, 1);
        nop(); in_brz = 1; in_rd1 = 32'h40;
        step();
        check("brz taken", {31'b0, br_taken}, 1);
        check("brz target", br_target, 32'h40);
        alu(3'b000, 1, 2, 6'd5); in_brz = 1; in_rd1 = 32'h80;
        step();
        check("squash br_taken", {31'b0, br_taken}, 0);
        check("squash out_regw", {31'b0, out_regw}, 0);
        check("squash flags", {30'b0, zero, neg}, 2);
        nop(); in_brn = 1; in_rd1 = 32'h90;
        step();
        check("brn not taken", {31'b0, br_taken}, 0);

        // NEG 1, LD, INC, PASS_B, reserved op
        alu(3'b010, 1, 0, 6'd6);
        step();
        check("neg out_alu", out_alu, 32'hFFFF_FFFF);
        check("neg flags", {30'b0, zero, neg}, 1);
        alu(3'b000, 32'h20, 32'h55, 6'd7); in_memr = 1; in_alusrc = 1; in_imm = 4;
        step();
        check("ld out_alu", out_alu, 32'h20);
        check("ld out_wdata", out_wdata, 32'h55);
        check("ld out_memr", {31'b0, out_memr}, 1);
        check("ld flags held", {30'b0, zero, neg}, 1);
        alu(3'b001, 10, 100, 6'd8); in_imm = 5;
        step();
        check("inc out_alu", out_alu, 15);
        check("inc flags", {30'b0, zero, neg}, 0);
        alu(3'b100, 3, 9, 6'd9); in_alusrc = 1; in_imm = 32'h1234;
        step();
        check("passb out_alu", out_alu, 32'h1234);
        alu(3'b111, 3, 9, 6'd9);
        step();
        check("rsv out_alu", out_alu, 0);
        check("rsv zero", {31'b0, zero}, 1);

        // Plain stall
        alu(3'b000, 2, 3, 6'd10);
        step();
        check("pre-stall out_alu", out_alu, 5);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            alu(3'b011, 100 + i, 1, 6'd11); in_j = 1;
            step();
            check("stall out_alu", out_alu, 5);
            check("stall out_rd", {26'b0, out_rd}, 10);
            check("stall br_taken", {31'b0, br_taken}, 0);
        end
        stall = 0;
        alu(3'b000, 6, 6, 6'd12);
        step();
        check("release out_alu", out_alu, 12);
        check("release out_rd", {26'b0, out_rd}, 12);

        // Jump pulse stretched across a stall
        nop(); in_j = 1; in_rd1 = 32'h200;
        step();
        check("j taken", {31'b0, br_taken}, 1);
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            nop(); in_j = 1; in_rd1 = 32'h300;
            step();
            check("j stall br_taken", {31'b0, br_taken}, 1);
            check("j stall br_target", br_target, 32'h200);
        end
        stall = 0;
        alu(3'b000, 1, 1, 6'd13);
        step();
        check("j release br_taken", {31'b0, br_taken}, 0);
        check("j release out_regw", {31'b0, out_regw}, 0);

        // Dependent ADD pair
        alu(3'b000, 3, 4, 6'd2);
        step();
        check("fwd src out_alu", out_alu, 7);
        alu(3'b000, 0, 1, 6'd14); in_rs = 6'd2; in_rt = 6'd9;
        step();
`ifdef EX_FWD_EN
        fwd_exp = 8;
`else
        fwd_exp = 1;
`endif
        check("fwd dep out_alu", out_alu, fwd_exp);

        // Reset during stall
        alu(3'b000, 9, 9, 6'd15); in_j = 1;
        stall = 1;
        step();
        rst = 1;
        step();
        check("rst-stall out_alu", out_alu, 0);
        check("rst-stall out_regw", {31'b0, out_regw}, 0);
        check("rst-stall out_rd", {26'b0, out_rd}, 0);
        check("rst-stall br_taken", {31'b0, br_taken}, 0);
        check("rst-stall flags", {30'b0, zero, neg}, 0);
        rst = 0; stall = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
